// File: rtl/vec_operand_loader.sv
// Bit-serial to parallel operand loader feeding the vector gate stage.
// Optional trailing even-parity check: define VEC_LOADER_PARITY_EN.
module vec_operand_loader #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       frame_cnt,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        PARITY = 2'd2,
        FULL   = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   sr_q;
    logic [2*WIDTH-1:0]   sr_d;
    logic                 accept;
    logic                 last;
    logic                 shift_en;
    logic                 load;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q == FULL);
    assign accept    = in_valid & in_ready;
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign shift_en  = accept & ((state_q == LOAD_A) | (state_q == LOAD_B));
    assign sr_d      = shift_en ? {in_bit, sr_q[2*WIDTH-1:1]} : sr_q;
    assign load      = (state_d == FULL) & (state_q != FULL);

`ifdef VEC_LOADER_PARITY_EN
    logic par_q;
    logic perr_q;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD_A: if (accept && last) state_d = LOAD_B;
`ifdef VEC_LOADER_PARITY_EN
            LOAD_B: if (accept && last) state_d = PARITY;
            PARITY: if (accept) state_d = (par_q ^ in_bit) ? LOAD_A : FULL;
`else
            LOAD_B: if (accept && last) state_d = FULL;
`endif
            FULL:   if (out_ready) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD_A;
            cnt_q     <= '0;
            sr_q      <= '0;
            a         <= '0;
            b         <= '0;
            frame_cnt <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            if (shift_en) cnt_q <= last ? '0 : cnt_q + CW'(1);
            // sr_d already holds the final data bit when it lands this edge
            if (load) begin
                a <= sr_d[WIDTH-1:0];
                b <= sr_d[2*WIDTH-1:WIDTH];
            end
            if (state_q == FULL && out_ready) frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef VEC_LOADER_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            perr_q <= (state_q == PARITY) & accept & (par_q ^ in_bit);
            if (state_q != LOAD_A && state_d == LOAD_A) par_q <= 1'b0;
            else if (accept) par_q <= par_q ^ in_bit;
        end
    end
`endif

endmodule

// File: tb/tb_vec_operand_loader.sv
// Directed bench for vec_operand_loader.
// Frames are given as f[k] = k-th serial bit (a = f[2:0], b = f[5:3]).
module tb_vec_operand_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       in_ready;
    logic [2:0] a;
    logic [2:0] b;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] frame_cnt;
    logic       parity_err;

    int total = 0;
    int bad = 0;

    vec_operand_loader #(.WIDTH(3)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_bit(in_bit),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_cnt(frame_cnt),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic bv);
        int n;
        in_valid = 1'b1;
        in_bit   = bv;
        n = 0;
        while (!in_ready && n < 8) begin
            cyc();
            n++;
        end
        if (!in_ready) chk("bit_timeout", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [5:0] f);
        for (int k = 0; k < 6; k++) send_bit(f[k]);
`ifdef VEC_LOADER_PARITY_EN
        send_bit(^f);
`endif
    endtask

    initial begin
        logic [5:0] g;
        logic [5:0] d;

        // reset state
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);

        // basic frame 1,0,1,1,1,0
        out_ready = 1'b1;
        send_frame(6'b011101);
        chk("basic_out_valid", 32'(out_valid), 32'd1);
        chk("basic_in_ready", 32'(in_ready), 32'd0);
        chk("basic_a", 32'(a), 32'h5);
        chk("basic_b", 32'(b), 32'h3);
        chk("basic_cnt_before", 32'(frame_cnt), 32'd0);
        cyc();
        chk("basic_cnt_after", 32'(frame_cnt), 32'd1);
        chk("basic_out_valid_fall", 32'(out_valid), 32'd0);
        chk("basic_in_ready_back", 32'(in_ready), 32'd1);
        chk("basic_a_held", 32'(a), 32'h5);

        // backpressure, with a bit offered during FULL that must not shift
        out_ready = 1'b0;
        send_frame(6'b001110);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_a", 32'(a), 32'h6);
            chk("bp_b", 32'(b), 32'h1);
            chk("bp_cnt", 32'(frame_cnt), 32'd1);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();
        chk("bp_cnt_after", 32'(frame_cnt), 32'd2);
        chk("bp_in_ready_after", 32'(in_ready), 32'd1);
        chk("bp_out_valid_after", 32'(out_valid), 32'd0);

        // gapped input: bits 0,1,1,0,0,1 on alternate cycles
        g = 6'b100110;
        for (int i = 0; i < 11; i++) begin
            in_valid = ~i[0];
            in_bit   = i[0] ? ~g[i/2] : g[i/2];
            cyc();
        end
        in_valid = 1'b0;
`ifdef VEC_LOADER_PARITY_EN
        send_bit(^g);
`endif
        chk("gap_out_valid", 32'(out_valid), 32'd1);
        chk("gap_a", 32'(a), 32'h6);
        chk("gap_b", 32'(b), 32'h4);
        cyc();
        chk("gap_cnt", 32'(frame_cnt), 32'd3);

        // reset mid-frame
        for (int k = 0; k < 4; k++) send_bit(k != 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_b", 32'(b), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        out_ready = 1'b0;
        send_frame(6'b000111);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd1);
        chk("mid_rst_a2", 32'(a), 32'h7);
        chk("mid_rst_b2", 32'(b), 32'h0);

        // reset while FULL with out_ready high: frame dropped, not counted
        out_ready = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("full_rst_out_valid", 32'(out_valid), 32'd0);
        chk("full_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("full_rst_a", 32'(a), 32'd0);

        // 256 back-to-back frames; the counter must wrap
        for (int i = 0; i < 256; i++) begin
            d = 6'(i * 37 + 5);
            send_frame(d);
            if (i == 100) begin
                chk("wrap_mid_a", 32'(a), 32'(d[2:0]));
                chk("wrap_mid_b", 32'(b), 32'(d[5:3]));
                chk("wrap_mid_cnt", 32'(frame_cnt), 32'd100);
            end
        end
        chk("wrap_out_valid", 32'(out_valid), 32'd1);
        chk("wrap_cnt_255", 32'(frame_cnt), 32'd255);
        cyc();
        chk("wrap_cnt_0", 32'(frame_cnt), 32'd0);
        d = 6'(255 * 37 + 5);

`ifdef VEC_LOADER_PARITY_EN
        // bad parity: error pulse, no frame, a/b unchanged
        for (int k = 0; k < 6; k++) send_bit(k == 0);
        send_bit(1'b0);
        chk("par_err_pulse", 32'(parity_err), 32'd1);
        chk("par_err_no_valid", 32'(out_valid), 32'd0);
        chk("par_err_a", 32'(a), 32'(d[2:0]));
        chk("par_err_b", 32'(b), 32'(d[5:3]));
        cyc();
        chk("par_err_clear", 32'(parity_err), 32'd0);
        for (int k = 0; k < 6; k++) send_bit(k == 0);
        send_bit(1'b1);
        chk("par_ok_valid", 32'(out_valid), 32'd1);
        chk("par_ok_a", 32'(a), 32'h1);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        cyc();
`else
        // without the parity build the trailing bit starts a new frame
        send_bit(1'b1);
        chk("nopar_err", 32'(parity_err), 32'd0);
        chk("nopar_a_held", 32'(a), 32'(d[2:0]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_operand_loader.md
Name: vec_operand_loader

Overview:
Serial-to-parallel operand front end for the 3-bit vector gate stage.
- Accepts a bit-serial stream over a valid/ready handshake and assembles operand a, then operand b.
- Presents the completed pair as registered, stable outputs under a valid/ready handshake to the downstream combinational vector-gate block.
- Counts delivered frames and, optionally, checks a trailing parity bit.

Parameters:
WIDTH, 3, bits per operand; one frame is 2*WIDTH data bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_bit carries a valid serial bit this cycle
in_bit  input  1  serial data bit; LSB-first, a before b
in_ready  output  1  loader can accept a bit this cycle
a  output  WIDTH  assembled operand a, registered
b  output  WIDTH  assembled operand b, registered
out_valid  output  1  a/b hold a complete frame
out_ready  input  1  downstream accepts the frame this cycle
frame_cnt  output  8  number of frames delivered, modulo 256
parity_err  output  1  one-cycle pulse on a parity-failed frame; tied 0 without macro

Behaviour:
- Single clock clk. Reset is synchronous, active-high: on a clk rising edge with reset=1, all state is cleared.
- Reset values: state=LOAD_A, bit counter=0, shift register=0, a=0, b=0, out_valid=0, in_ready=1, frame_cnt=0, parity_err=0.
- Bit accept: a bit is accepted only on an edge where in_valid & in_ready. in_bit is ignored when in_valid=0.
- Shift order: shift register is right-shift, LSB-first. Bit k of the operand is the k-th bit accepted for it.
- States:
  - LOAD_A: in_ready=1. After accepting WIDTH bits → LOAD_B, counter cleared.
  - LOAD_B: in_ready=1. After accepting WIDTH bits:
    - → PARITY if the macro is defined;
    - otherwise → FULL, with a/b loaded from the shift register on the same edge.
  - PARITY (macro only): in_ready=1. Accepts one bit, then:
    - even parity over all 2*WIDTH+1 bits OK → FULL, a/b loaded;
    - mismatch → LOAD_A, a/b unchanged, parity_err=1 for exactly the next cycle.
  - FULL: out_valid=1, in_ready=0. Stays until out_valid & out_ready on an edge, then:
    - → LOAD_A;
    - frame_cnt increments, wrapping 255 → 0.
- Latency: out_valid rises on the cycle immediately after the edge that accepts the final frame bit.
- Transfer timing: out_valid falls on the cycle after the transfer edge. Earliest next frame bit is accepted in that same cycle (no bubble beyond the one FULL cycle).
- Stability: while out_valid=1, a and b do not change. They also hold their last frame value after the transfer, until the next complete frame loads.
- in_ready is a registered function of state only. There is no combinational path from out_ready to in_ready.
- Bits offered with in_valid=1 in FULL are not accepted. The producer must hold them.
- Reset mid-frame: partial bits are discarded and a/b return to 0. If reset is asserted in FULL, the pending frame is dropped without counting.
- reset has priority over every other event on the same edge.

Optional Feature:
Macro VEC_LOADER_PARITY_EN.
- Defined: the PARITY state exists, frames are 2*WIDTH+1 bits with even parity, and parity_err behaves as above.
- Undefined: no PARITY state, frames are 2*WIDTH bits, and parity_err is constant 0.
- The port list is identical in both builds.

Test Plan:
- Basic frame, WIDTH=3, out_ready=1: stream 1,0,1,1,1,0 on consecutive cycles → out_valid=1 on the next cycle with a=3'b101, b=3'b011; frame_cnt 0→1 on the transfer edge.
- Backpressure: complete frame a=3'b110, b=3'b001, out_ready=0 for 5 cycles → out_valid=1, in_ready=0, a/b stable for all 5 cycles; on the out_ready=1 edge, frame_cnt +1 and in_ready=1 on the next cycle.
- Gapped input: in_valid toggled 1,0,1,0,… across 12 cycles with bits 0,1,1,0,0,1 → a=3'b110, b=3'b100; bits in in_valid=0 cycles do not shift.
- Reset mid-frame: 4 bits accepted, then reset=1 for 1 cycle → a=b=0, state LOAD_A; the following 6 bits 1,1,1,0,0,0 → a=3'b111, b=3'b000.
- Wrap: 256 back-to-back frames delivered → frame_cnt returns to 0 after the 256th transfer.
- With VEC_LOADER_PARITY_EN:
  - frame 1,0,0,0,0,0 with parity bit 0 → parity_err=1 for one cycle, out_valid stays 0, a/b unchanged;
  - same frame with parity bit 1 → out_valid=1, a=3'b001.
